// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed LED display driver.
// Scans NUM_DIGITS digits one slot at a time. Each digit shows either a decoded
// hex nibble (with optional decimal point) or a raw segment pattern, and can be
// blanked. Brightness comes from the on-window at the start of each slot.
// Display contents are double-buffered: loads land in a staging set that is
// copied to the active set only at a frame boundary, so a frame never tears.
module seg_scan_mux #(
    parameter int NUM_DIGITS       = 3,
    parameter int NUM_SEGS         = 8,
    parameter int SCAN_BITS        = 18,
    parameter int BRIGHT_BITS      = 4,
    parameter int DIGIT_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [NUM_DIGITS*4-1:0]        data,
    input  logic [NUM_DIGITS*NUM_SEGS-1:0] raw_segs,
    input  logic [NUM_DIGITS-1:0]          raw,
    input  logic [NUM_DIGITS-1:0]          dp,
    input  logic [NUM_DIGITS-1:0]          blank,
    input  logic [BRIGHT_BITS-1:0]         bright,
    output logic                           pending,
    output logic                           frame_tick,
    output logic [NUM_DIGITS-1:0]          DIGIT,
    output logic [NUM_SEGS-1:0]            SEG
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // Pin levels meaning "off", i.e. the polarity masks applied after all logic.
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_SEGS-1:0]   SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    // Hex nibble to gfedcba segment pattern.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        f = 7'h00;
        case (nib)
            4'h0: f = 7'h3F;
            4'h1: f = 7'h06;
            4'h2: f = 7'h5B;
            4'h3: f = 7'h4F;
            4'h4: f = 7'h66;
            4'h5: f = 7'h6D;
            4'h6: f = 7'h7D;
            4'h7: f = 7'h07;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h6F;
            4'hA: f = 7'h77;
            4'hB: f = 7'h7C;
            4'hC: f = 7'h39;
            4'hD: f = 7'h5E;
            4'hE: f = 7'h79;
            4'hF: f = 7'h71;
            default: f = 7'h00;
        endcase
        return f;
    endfunction

    logic [SCAN_BITS-1:0] cnt_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 pending_reg;
    logic                 frame_tick_reg;

    logic [NUM_DIGITS*4-1:0]        act_data_reg,     stg_data_reg;
    logic [NUM_DIGITS*NUM_SEGS-1:0] act_raw_segs_reg, stg_raw_segs_reg;
    logic [NUM_DIGITS-1:0]          act_raw_reg,      stg_raw_reg;
    logic [NUM_DIGITS-1:0]          act_dp_reg,       stg_dp_reg;
    logic [NUM_DIGITS-1:0]          act_blank_reg,    stg_blank_reg;
    logic [BRIGHT_BITS-1:0]         act_bright_reg,   stg_bright_reg;

    logic [NUM_DIGITS-1:0] digit_reg, digit_next;
    logic [NUM_SEGS-1:0]   seg_reg,   seg_next;

    logic boundary;
    logic commit;

    // The last cycle of the last digit slot closes the frame.
    assign boundary = (cnt_reg == '1) && (idx_reg == LAST_IDX);
    // A load on the boundary itself is committed straight away.
    assign commit   = boundary && (pending_reg || load);

    // Scan counter and digit index; idx steps when the slot counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_reg + 1'b1;
            frame_tick_reg <= boundary;
            if (cnt_reg == '1) begin
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // Staging set: latest load wins until the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_data_reg     <= '0;
            stg_raw_segs_reg <= '0;
            stg_raw_reg      <= '0;
            stg_dp_reg       <= '0;
            stg_blank_reg    <= '1;
            stg_bright_reg   <= '1;
        end else if (load) begin
            stg_data_reg     <= data;
            stg_raw_segs_reg <= raw_segs;
            stg_raw_reg      <= raw;
            stg_dp_reg       <= dp;
            stg_blank_reg    <= blank;
            stg_bright_reg   <= bright;
        end
    end

    // Pending flag: set by a load, cleared by any boundary (which commits it).
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
        end else if (boundary) begin
            pending_reg <= 1'b0;
        end else if (load) begin
            pending_reg <= 1'b1;
        end
    end

    // Active set: copied from staging (or directly from the inputs) at a boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_data_reg     <= '0;
            act_raw_segs_reg <= '0;
            act_raw_reg      <= '0;
            act_dp_reg       <= '0;
            act_blank_reg    <= '1;
            act_bright_reg   <= '1;
        end else if (commit) begin
            act_data_reg     <= load ? data     : stg_data_reg;
            act_raw_segs_reg <= load ? raw_segs : stg_raw_segs_reg;
            act_raw_reg      <= load ? raw      : stg_raw_reg;
            act_dp_reg       <= load ? dp       : stg_dp_reg;
            act_blank_reg    <= load ? blank    : stg_blank_reg;
            act_bright_reg   <= load ? bright   : stg_bright_reg;
        end
    end

    // Per-digit segment pattern from the active set.
    logic [NUM_DIGITS-1:0][NUM_SEGS-1:0] pat;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pat
        logic [3:0] nib;
        assign nib     = act_data_reg[4*gi +: 4];
        assign pat[gi] = act_raw_reg[gi] ? act_raw_segs_reg[NUM_SEGS*gi +: NUM_SEGS]
                                         : NUM_SEGS'({act_dp_reg[gi], hex_font(nib)});
    end

    // Select the scanned digit and decide whether it is lit this cycle.
    always_comb begin
        logic [NUM_SEGS-1:0] sel_pat;
        logic                sel_blank;
        logic                digit_on;
        sel_pat   = '0;
        sel_blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sel_pat   = pat[i];
                sel_blank = act_blank_reg[i];
            end
        end
        // The top bits of the slot counter give the on-window; bright never
        // reaches 2^BRIGHT_BITS, so every slot ends with some dead time.
        digit_on   = (cnt_reg[SCAN_BITS-1 -: BRIGHT_BITS] < act_bright_reg) && !sel_blank;
        digit_next = digit_on ? (NUM_DIGITS'(1) << idx_reg) : '0;
        seg_next   = digit_on ? sel_pat : '0;
    end

    // Output registers, polarity applied before the flop so the pins are clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_reg <= DIGIT_OFF;
            seg_reg   <= SEG_OFF;
        end else begin
            digit_reg <= digit_next ^ DIGIT_OFF;
            seg_reg   <= seg_next ^ SEG_OFF;
        end
    end

    assign pending    = pending_reg;
    assign frame_tick = frame_tick_reg;
    assign DIGIT      = digit_reg;
    assign SEG        = seg_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with SCAN_BITS=4, BRIGHT_BITS=2, three digits,
// active-low digit enables and active-high segments (48-cycle frame).
module tb_seg_scan_mux;

    typedef struct packed {
        logic [11:0] data;
        logic [23:0] raw_segs;
        logic [2:0]  raw;
        logic [2:0]  dp;
        logic [2:0]  blank;
        logic [1:0]  bright;
    } cfg_t;

    typedef struct {
        cfg_t        cfg;
        logic [23:0] exp_segs;
        int          on0;
        int          on1;
        int          on2;
    } vec_t;

    localparam cfg_t RST_CFG = '{data: 12'h0, raw_segs: 24'h0, raw: 3'b0, dp: 3'b0,
                                 blank: 3'b111, bright: 2'b11};

    logic       clk;
    logic       rst;
    logic       load;
    cfg_t       in_cfg;
    logic       pending;
    logic       frame_tick;
    logic [2:0] DIGIT;
    logic [7:0] SEG;

    seg_scan_mux #(
        .NUM_DIGITS(3), .NUM_SEGS(8), .SCAN_BITS(4), .BRIGHT_BITS(2),
        .DIGIT_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .load(load),
        .data(in_cfg.data), .raw_segs(in_cfg.raw_segs), .raw(in_cfg.raw),
        .dp(in_cfg.dp), .blank(in_cfg.blank), .bright(in_cfg.bright),
        .pending(pending), .frame_tick(frame_tick), .DIGIT(DIGIT), .SEG(SEG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: position within the frame (0..47), register sets, pending.
    int   m_t    = 0;
    cfg_t m_act  = RST_CFG;
    cfg_t m_stg  = RST_CFG;
    logic m_pend = 1'b0;

    int obs_on [3];
    int obs_bad;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pattern(input cfg_t c, input int d);
        if (c.raw[d]) return c.raw_segs[d*8 +: 8];
        return {c.dp[d], font_tab[c.data[d*4 +: 4]]};
    endfunction

    // One clock: predict the post-edge outputs, clock, then compare.
    task automatic cycle();
        logic [2:0] e_dig;
        logic [7:0] e_seg;
        logic       e_ft;
        int         d;
        int         quarter;
        if (rst) begin
            m_t    = 0;
            m_act  = RST_CFG;
            m_stg  = RST_CFG;
            m_pend = 1'b0;
            e_ft   = 1'b0;
            e_dig  = 3'b111;
            e_seg  = 8'h00;
        end else begin
            d       = m_t / 16;
            quarter = (m_t % 16) / 4;
            if (quarter < int'(m_act.bright) && !m_act.blank[d]) begin
                e_dig = ~(3'b001 << d);
                e_seg = pattern(m_act, d);
            end else begin
                e_dig = 3'b111;
                e_seg = 8'h00;
            end
            e_ft = (m_t == 47);
            if (e_ft && (m_pend || load)) m_act = load ? in_cfg : m_stg;
            if (load) m_stg = in_cfg;
            m_pend = e_ft ? 1'b0 : (load ? 1'b1 : m_pend);
            m_t    = (m_t + 1) % 48;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("digit", {29'd0, DIGIT}, {29'd0, e_dig});
        chk("seg", {24'd0, SEG}, {24'd0, e_seg});
        chk("pending", {31'd0, pending}, {31'd0, m_pend});
        chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_ft});
    endtask

    task automatic do_load(input cfg_t c);
        in_cfg = c;
        load   = 1'b1;
        $display("load cycle=%0d data=%h raw_segs=%h raw=%b dp=%b blank=%b bright=%0d",
                 cyc, c.data, c.raw_segs, c.raw, c.dp, c.blank, c.bright);
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        chk(name, {31'd0, n < 100}, 32'd1);
    endtask

    task automatic wait_mt(input int target);
        int n;
        n = 0;
        while (m_t != target && n < 100) begin
            cycle();
            n++;
        end
    endtask

    // Watch n cycles: count lit cycles per digit and wrong segment values.
    task automatic observe(input logic [23:0] exp_segs, input int n);
        obs_on[0] = 0; obs_on[1] = 0; obs_on[2] = 0;
        obs_bad   = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            for (int d = 0; d < 3; d++) begin
                if (DIGIT[d] === 1'b0) begin
                    obs_on[d]++;
                    if (SEG !== exp_segs[8*d +: 8]) obs_bad++;
                end
            end
        end
    endtask

    task automatic set_vec(input int i, input logic [11:0] data, input logic [23:0] rs,
                           input logic [2:0] raw, input logic [2:0] dp, input logic [2:0] blank,
                           input logic [1:0] bright, input logic [23:0] segs,
                           input int on0, input int on1, input int on2);
        vecs[i].cfg.data     = data;
        vecs[i].cfg.raw_segs = rs;
        vecs[i].cfg.raw      = raw;
        vecs[i].cfg.dp       = dp;
        vecs[i].cfg.blank    = blank;
        vecs[i].cfg.bright   = bright;
        vecs[i].exp_segs     = segs;
        vecs[i].on0          = on0;
        vecs[i].on1          = on1;
        vecs[i].on2          = on2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   ticks [$];
        int   c0;
        cfg_t c;
        logic [63:0] r;

        // exp_segs holds digit2, digit1, digit0 from MSB to LSB.
        set_vec(0, 12'h1A3, 24'h0,      3'b000, 3'b000, 3'b000, 2'd3, 24'h06774F, 12, 12, 12);
        set_vec(1, 12'h1A3, 24'h0,      3'b000, 3'b000, 3'b000, 2'd1, 24'h06774F, 4, 4, 4);
        set_vec(2, 12'h1A3, 24'h0,      3'b000, 3'b000, 3'b000, 2'd0, 24'h06774F, 0, 0, 0);
        set_vec(3, 12'h1A3, 24'h00A500, 3'b010, 3'b111, 3'b100, 2'd3, 24'h00A5CF, 12, 12, 0);
        set_vec(4, 12'hE0F, 24'h0,      3'b000, 3'b001, 3'b010, 2'd2, 24'h793FF1, 8, 0, 8);
        set_vec(5, 12'h000, 24'h123456, 3'b111, 3'b111, 3'b000, 2'd3, 24'h123456, 12, 12, 12);

        rst    = 1'b1;
        load   = 1'b0;
        in_cfg = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // No load: dark display, frame_tick every 48 cycles.
        c0 = cyc;
        for (int k = 0; k < 150; k++) begin
            cycle();
            if (frame_tick === 1'b1) ticks.push_back(cyc);
        end
        chk("tick_count", ticks.size(), 3);
        if (ticks.size() >= 3) begin
            chk("first_tick", ticks[0] - c0, 48);
            chk("tick_period_a", ticks[1] - ticks[0], 48);
            chk("tick_period_b", ticks[2] - ticks[1], 48);
        end

        // Two loads in one frame, then a load on the boundary cycle.
        c = '{data: 12'h111, raw_segs: 24'h0, raw: 3'b0, dp: 3'b0, blank: 3'b0, bright: 2'd3};
        wait_mt(3);
        do_load(c);
        chk("pend_after_load1", {31'd0, pending}, 32'd1);
        wait_mt(20);
        c.data = 12'h222;
        do_load(c);
        chk("pend_after_load2", {31'd0, pending}, 32'd1);
        wait_tick("commit_222_wait");
        chk("pend_after_commit", {31'd0, pending}, 32'd0);
        observe(24'h5B5B5B, 47);
        chk("only_222_bad", obs_bad, 0);
        chk("only_222_on0", obs_on[0], 12);
        chk("only_222_on2", obs_on[2], 12);
        c.data = 12'h333;
        do_load(c);
        chk("boundary_load_tick", {31'd0, frame_tick}, 32'd1);
        chk("boundary_load_pend", {31'd0, pending}, 32'd0);
        observe(24'h4F4F4F, 48);
        chk("boundary_val_bad", obs_bad, 0);
        chk("boundary_val_on1", obs_on[1], 12);

        // Table of display configurations, each checked over one whole frame.
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].cfg);
            wait_tick($sformatf("vec%0d_wait", i));
            observe(vecs[i].exp_segs, 48);
            chk($sformatf("vec%0d_seg", i), obs_bad, 0);
            chk($sformatf("vec%0d_on0", i), obs_on[0], vecs[i].on0);
            chk($sformatf("vec%0d_on1", i), obs_on[1], vecs[i].on1);
            chk($sformatf("vec%0d_on2", i), obs_on[2], vecs[i].on2);
        end

        // Reset mid-frame with a load pending: staging discarded, display dark.
        c = '{data: 12'h1A3, raw_segs: 24'h0, raw: 3'b0, dp: 3'b0, blank: 3'b0, bright: 2'd3};
        wait_mt(10);
        do_load(c);
        chk("rst_pend_before", {31'd0, pending}, 32'd1);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_pend", {31'd0, pending}, 32'd0);
        chk("rst_digit", {29'd0, DIGIT}, 32'd7);
        chk("rst_seg", {24'd0, SEG}, 32'd0);
        observe(24'h0, 100);
        chk("rst_dark", obs_on[0] + obs_on[1] + obs_on[2], 0);

        // Random loads and occasional resets against the model.
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!rst && $urandom_range(0, 7) == 0) begin
                r = {$urandom, $urandom};
                do_load(r[46:0]);
            end else begin
                cycle();
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
